// File: rtl/alu_ctrl_regfile.sv
// Execute-stage datapath: 32x32 register file with write-through bypass,
// instruction decode, ALU with 64-bit multiply, HI/LO registers and GPIO select.
module alu_ctrl_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] gpio_in,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] alu_lo,
    output logic [31:0] alu_hi,
    output logic        zero,
    output logic [31:0] rt_data,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_src,
    output logic        regwrite,
    output logic [4:0]  writeaddr,
    output logic [31:0] ex_result,
    output logic        gpio_out_en,
    output logic        gpio_in_en
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_MULT = 4'd6;
    localparam logic [3:0] OP_MULU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;

    localparam logic [1:0] SRC_RT   = 2'd0;
    localparam logic [1:0] SRC_SEXT = 2'd1;
    localparam logic [1:0] SRC_ZEXT = 2'd2;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_HI  = 2'd1;
    localparam logic [1:0] SEL_LO  = 2'd2;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    logic [31:0] regs [0:31];
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] a_data;
    logic [31:0] b_val;
    logic [4:0]  sh_amt;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        hilo_we;
    logic [1:0]  regsel;

    // Reads see a same-cycle writeback to the addressed register.
    assign a_data  = (rs == 5'd0) ? '0 :
                     (wb_we && wb_addr == rs) ? wb_data : regs[rs];
    assign rt_data = (rt == 5'd0) ? '0 :
                     (wb_we && wb_addr == rt) ? wb_data : regs[rt];

    assign writeaddr = (opcode == OPC_RTYPE) ? rd : rt;

    always_comb begin
        alu_op      = OP_AND;
        alu_src     = SRC_RT;
        regwrite    = 1'b0;
        hilo_we     = 1'b0;
        regsel      = SEL_ALU;
        gpio_in_en  = 1'b0;
        gpio_out_en = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                regwrite = 1'b1;
                case (funct)
                    6'h00:         alu_op = OP_SLL;
                    6'h02:         alu_op = OP_SRL;
                    6'h03:         alu_op = OP_SRA;
                    6'h20, 6'h21:  alu_op = OP_ADD;
                    6'h22, 6'h23:  alu_op = OP_SUB;
                    6'h24:         alu_op = OP_AND;
                    6'h25:         alu_op = OP_OR;
                    6'h26:         alu_op = OP_XOR;
                    6'h27:         alu_op = OP_NOR;
                    6'h2A:         alu_op = OP_SLT;
                    6'h2B:         alu_op = OP_SLTU;
                    6'h18: begin
                        alu_op   = OP_MULT;
                        regwrite = 1'b0;
                        hilo_we  = 1'b1;
                    end
                    6'h19: begin
                        alu_op   = OP_MULU;
                        regwrite = 1'b0;
                        hilo_we  = 1'b1;
                    end
                    6'h10:         regsel = SEL_HI;
                    6'h12:         regsel = SEL_LO;
                    default:       regwrite = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin alu_op = OP_ADD;  alu_src = SRC_SEXT; regwrite = 1'b1; end
            6'h0A:        begin alu_op = OP_SLT;  alu_src = SRC_SEXT; regwrite = 1'b1; end
            6'h0B:        begin alu_op = OP_SLTU; alu_src = SRC_SEXT; regwrite = 1'b1; end
            6'h0C:        begin alu_op = OP_AND;  alu_src = SRC_ZEXT; regwrite = 1'b1; end
            6'h0D:        begin alu_op = OP_OR;   alu_src = SRC_ZEXT; regwrite = 1'b1; end
            6'h0E:        begin alu_op = OP_XOR;  alu_src = SRC_ZEXT; regwrite = 1'b1; end
            OPC_LUI:      begin alu_op = OP_SLL;  alu_src = SRC_ZEXT; regwrite = 1'b1; end
            6'h3E: begin
                regwrite   = 1'b1;
                gpio_in_en = 1'b1;
            end
            6'h3F:        gpio_out_en = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (alu_src)
            SRC_SEXT: b_val = {{16{imm[15]}}, imm};
            SRC_ZEXT: b_val = {16'h0000, imm};
            default:  b_val = rt_data;
        endcase
    end

    // LUI reuses the SLL path with a fixed shift of 16.
    assign sh_amt = (opcode == OPC_LUI) ? 5'd16 : shamt;
    assign prod_s = {{32{a_data[31]}}, a_data} * {{32{b_val[31]}}, b_val};
    assign prod_u = {32'h0, a_data} * {32'h0, b_val};

    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        case (alu_op)
            OP_AND:  alu_lo = a_data & b_val;
            OP_OR:   alu_lo = a_data | b_val;
            OP_XOR:  alu_lo = a_data ^ b_val;
            OP_NOR:  alu_lo = ~(a_data | b_val);
            OP_ADD:  alu_lo = a_data + b_val;
            OP_SUB:  alu_lo = a_data - b_val;
            OP_MULT: {alu_hi, alu_lo} = prod_s;
            OP_MULU: {alu_hi, alu_lo} = prod_u;
            OP_SLL:  alu_lo = b_val << sh_amt;
            OP_SRL:  alu_lo = b_val >> sh_amt;
            OP_SRA:  alu_lo = $unsigned($signed(b_val) >>> sh_amt);
            OP_SLT:  alu_lo = {31'h0, $signed(a_data) < $signed(b_val)};
            OP_SLTU: alu_lo = {31'h0, a_data < b_val};
            default: ;
        endcase
    end

    assign zero = (alu_lo == 32'h0);

    always_comb begin
        if (gpio_in_en)
            ex_result = gpio_in;
        else if (regsel == SEL_HI)
            ex_result = hi_reg;
        else if (regsel == SEL_LO)
            ex_result = lo_reg;
        else
            ex_result = alu_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[i[4:0]] <= '0;
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            if (wb_we && wb_addr != 5'd0)
                regs[wb_addr] <= wb_data;
            if (hilo_we) begin
                hi_reg <= alu_hi;
                lo_reg <= alu_lo;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_regfile.sv
// Self-checking bench for alu_ctrl_regfile: instruction-level reference model
// compared every cycle, directed literal checks, then randomized traffic.
module tb_alu_ctrl_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] gpio_in;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] alu_lo;
    logic [31:0] alu_hi;
    logic        zero;
    logic [31:0] rt_data;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src;
    logic        regwrite;
    logic [4:0]  writeaddr;
    logic [31:0] ex_result;
    logic        gpio_out_en;
    logic        gpio_in_en;

    alu_ctrl_regfile dut (
        .clk(clk), .rst(rst), .instr(instr), .gpio_in(gpio_in),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .alu_lo(alu_lo), .alu_hi(alu_hi), .zero(zero), .rt_data(rt_data),
        .alu_op(alu_op), .alu_src(alu_src), .regwrite(regwrite),
        .writeaddr(writeaddr), .ex_result(ex_result),
        .gpio_out_en(gpio_out_en), .gpio_in_en(gpio_in_en)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic chk_en = 1'b0;

    logic [31:0] m_regs [0:31];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] ex;
        logic [31:0] rt;
        logic [3:0]  op;
        logic [1:0]  src;
        logic [4:0]  waddr;
        logic        regwrite;
        logic        gin;
        logic        gout;
        logic        mul;
        logic        alu_chk;
        logic        ex_chk;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] ad, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (ad == 5'd0) return 32'h0;
        if (we && wa == ad) return wd;
        return m_regs[ad];
    endfunction

    // Instruction semantics straight from the ISA description.
    function automatic exp_t model(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                                   input logic [31:0] wd, input logic [31:0] gin);
        exp_t e;
        logic [31:0] a, b, se, ze;
        logic [4:0]  sa;
        logic [5:0]  opc, fn;
        longint sp;
        longint unsigned up;
        e   = '0;
        opc = ins[31:26];
        fn  = ins[5:0];
        sa  = ins[10:6];
        a   = rd_reg(ins[25:21], we, wa, wd);
        b   = rd_reg(ins[20:16], we, wa, wd);
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0, ins[15:0]};
        e.rt = b;
        if (opc == 6'h00) begin
            e.waddr = ins[15:11]; e.regwrite = 1; e.alu_chk = 1; e.ex_chk = 1;
            case (fn)
                6'h00: begin e.op = 8;  e.lo = b << sa; end
                6'h02: begin e.op = 9;  e.lo = b >> sa; end
                6'h03: begin e.op = 10; e.lo = (b >> sa) | (b[31] ? ~(32'hFFFFFFFF >> sa) : 32'h0); end
                6'h20, 6'h21: begin e.op = 4; e.lo = a + b; end
                6'h22, 6'h23: begin e.op = 5; e.lo = a - b; end
                6'h24: begin e.op = 0; e.lo = a & b; end
                6'h25: begin e.op = 1; e.lo = a | b; end
                6'h26: begin e.op = 2; e.lo = a ^ b; end
                6'h27: begin e.op = 3; e.lo = ~(a | b); end
                6'h2A: begin e.op = 11; e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                6'h2B: begin e.op = 12; e.lo = (a < b) ? 32'd1 : 32'd0; end
                6'h18: begin
                    e.op = 6; sp = longint'($signed(a)) * longint'($signed(b));
                    {e.hi, e.lo} = sp; e.regwrite = 0; e.mul = 1;
                end
                6'h19: begin
                    e.op = 7; up = longint'({32'h0, a}) * longint'({32'h0, b});
                    {e.hi, e.lo} = up; e.regwrite = 0; e.mul = 1;
                end
                6'h10: begin e.alu_chk = 0; e.ex = m_hi; end
                6'h12: begin e.alu_chk = 0; e.ex = m_lo; end
                default: begin e.regwrite = 0; e.alu_chk = 0; e.ex_chk = 0; end
            endcase
        end else begin
            e.waddr = ins[20:16];
            e.regwrite = 1; e.alu_chk = 1; e.ex_chk = 1;
            case (opc)
                6'h08, 6'h09: begin e.op = 4;  e.src = 1; e.lo = a + se; end
                6'h0A: begin e.op = 11; e.src = 1; e.lo = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
                6'h0B: begin e.op = 12; e.src = 1; e.lo = (a < se) ? 32'd1 : 32'd0; end
                6'h0C: begin e.op = 0; e.src = 2; e.lo = a & ze; end
                6'h0D: begin e.op = 1; e.src = 2; e.lo = a | ze; end
                6'h0E: begin e.op = 2; e.src = 2; e.lo = a ^ ze; end
                6'h0F: begin e.op = 8; e.src = 2; e.lo = {ins[15:0], 16'h0}; end
                6'h3E: begin e.alu_chk = 0; e.gin = 1; e.ex = gin; end
                6'h3F: begin e.alu_chk = 0; e.ex_chk = 0; e.regwrite = 0; e.gout = 1; end
                default: begin e.regwrite = 0; e.alu_chk = 0; e.ex_chk = 0; end
            endcase
        end
        if (e.alu_chk) e.ex = e.lo;
        return e;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            e = model(instr, wb_we, wb_addr, wb_data, gpio_in);
            chk("m_rt_data", rt_data, e.rt);
            chk("m_alu_hi", alu_hi, e.hi);
            chk("m_regwrite", {31'h0, regwrite}, {31'h0, e.regwrite});
            chk("m_gpio_in_en", {31'h0, gpio_in_en}, {31'h0, e.gin});
            chk("m_gpio_out_en", {31'h0, gpio_out_en}, {31'h0, e.gout});
            if (e.regwrite) chk("m_writeaddr", {27'h0, writeaddr}, {27'h0, e.waddr});
            if (e.alu_chk) begin
                chk("m_alu_lo", alu_lo, e.lo);
                chk("m_alu_op", {28'h0, alu_op}, {28'h0, e.op});
                chk("m_alu_src", {30'h0, alu_src}, {30'h0, e.src});
                chk("m_zero", {31'h0, zero}, {31'h0, (e.lo == 32'h0)});
            end
            if (e.ex_chk) chk("m_ex_result", ex_result, e.ex);
            if (rst) begin
                for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
                m_hi = 32'h0;
                m_lo = 32'h0;
            end else begin
                if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
                if (e.mul) begin m_hi = e.hi; m_lo = e.lo; end
            end
        end
    end

    task automatic step(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic r);
        @(posedge clk);
        #1;
        instr = ins; wb_we = we; wb_addr = wa; wb_data = wd; rst = r;
        @(negedge clk);
    endtask

    logic [5:0] rf_tab [0:16] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                  6'h26, 6'h27, 6'h2A, 6'h2B, 6'h18, 6'h19, 6'h10, 6'h12};
    logic [5:0] io_tab [0:9]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3E, 6'h3F};

    initial begin
        logic [31:0] ins;
        int unsigned k;
        rst = 1'b1; instr = '0; gpio_in = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);

        step(32'h0, 0, 0, 0, 0);
        chk("rst_regwrite", {31'h0, regwrite}, 32'd1);
        chk("rst_writeaddr", {27'h0, writeaddr}, 32'd0);
        chk("rst_rt_data", rt_data, 32'h0);
        chk("rst_zero", {31'h0, zero}, 32'd1);
        step(32'h00002810, 0, 0, 0, 0);
        chk("rst_mfhi", ex_result, 32'h0);

        step(32'h20010005, 0, 0, 0, 0);
        chk("addi_lo", alu_lo, 32'd5);
        chk("addi_waddr", {27'h0, writeaddr}, 32'd1);
        step(32'h00211820, 1, 5'd1, 32'd5, 0);
        chk("add_lo", alu_lo, 32'd10);
        chk("add_waddr", {27'h0, writeaddr}, 32'd3);

        step(32'h0020102A, 1, 5'd1, 32'hFFFFFFFF, 0);
        chk("slt_lo", alu_lo, 32'd1);
        step(32'h0020102B, 0, 0, 0, 0);
        chk("sltu_lo", alu_lo, 32'd0);
        step(32'h00211022, 0, 0, 0, 0);
        chk("sub_lo", alu_lo, 32'd0);
        chk("sub_zero", {31'h0, zero}, 32'd1);

        step(32'h0, 1, 5'd1, 32'hFFFFFFFE, 0);
        step(32'h0, 1, 5'd2, 32'd3, 0);
        step(32'h00220018, 0, 0, 0, 0);
        chk("mult_hi", alu_hi, 32'hFFFFFFFF);
        step(32'h00002810, 0, 0, 0, 0);
        chk("mult_mfhi", ex_result, 32'hFFFFFFFF);
        step(32'h00002812, 0, 0, 0, 0);
        chk("mult_mflo", ex_result, 32'hFFFFFFFA);
        step(32'h00220019, 0, 0, 0, 0);
        step(32'h00002810, 0, 0, 0, 0);
        chk("multu_mfhi", ex_result, 32'd2);
        step(32'h00002812, 0, 0, 0, 0);
        chk("multu_mflo", ex_result, 32'hFFFFFFFA);

        step(32'h3C041234, 0, 0, 0, 0);
        chk("lui_lo", alu_lo, 32'h12340000);
        step(32'h34048000, 0, 0, 0, 0);
        chk("ori_lo", alu_lo, 32'h00008000);
        step(32'h20048000, 0, 0, 0, 0);
        chk("addi_neg_lo", alu_lo, 32'hFFFF8000);

        step(32'h04000000, 0, 0, 0, 0);
        chk("nop_opc_regwrite", {31'h0, regwrite}, 32'd0);
        step(32'h0000003F, 0, 0, 0, 0);
        chk("nop_fn_regwrite", {31'h0, regwrite}, 32'd0);

        gpio_in = 32'hA5A5A5A5;
        step(32'hF8070000, 0, 0, 0, 0);
        chk("gpin_en", {31'h0, gpio_in_en}, 32'd1);
        chk("gpin_ex", ex_result, 32'hA5A5A5A5);
        chk("gpin_waddr", {27'h0, writeaddr}, 32'd7);
        step(32'hFC070000, 1, 5'd7, 32'hA5A5A5A5, 0);
        step(32'hFC070000, 0, 0, 0, 0);
        chk("gpout_en", {31'h0, gpio_out_en}, 32'd1);
        chk("gpout_rt", rt_data, 32'hA5A5A5A5);

        step(32'hFC000000, 1, 5'd0, 32'h0000DEAD, 0);
        chk("r0_wr_same", rt_data, 32'h0);
        step(32'hFC000000, 0, 0, 0, 0);
        chk("r0_wr_after", rt_data, 32'h0);
        step(32'hFC050000, 1, 5'd5, 32'h12345678, 0);
        chk("bypass_rt", rt_data, 32'h12345678);
        step(32'h00A50018, 1, 5'd6, 32'h00000077, 1);
        chk("pre_rst_r5", rt_data, 32'h12345678);
        step(32'hFC050000, 0, 0, 0, 0);
        chk("post_rst_r5", rt_data, 32'h0);
        step(32'h00003012, 0, 0, 0, 0);
        chk("post_rst_mflo", ex_result, 32'h0);
        step(32'hFC060000, 0, 0, 0, 0);
        chk("post_rst_r6", rt_data, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 28);
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            if (k < 17) begin
                ins[31:26] = 6'h00;
                ins[15:11] = 5'($urandom_range(0, 7));
                ins[5:0]   = rf_tab[k];
            end else if (k < 27) begin
                ins[31:26] = io_tab[k - 17];
            end else if (k == 28) begin
                ins[31:26] = 6'h00;
            end
            gpio_in = $urandom;
            step(ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 63) == 0));
        end

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
